// File: rtl/timer_bus_pkg.sv
// -----------------------------------------------------------------------------
// timer_bus_pkg
// Shared definitions for the timer register bus initiator:
//   - state_t      : initiator FSM state encoding
//   - DEF_ADDR_W / DEF_DATA_W : default bus widths
//   - *_ADDR       : timer register map, for benches and command sequencers
// -----------------------------------------------------------------------------
package timer_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;

    // Timer register map
    localparam logic [5:0] CTRL_ADDR  = 6'h00;
    localparam logic [5:0] PRESC_ADDR = 6'h01;
    localparam logic [5:0] CMP_ADDR   = 6'h02;
    localparam logic [5:0] STAT_ADDR  = 6'h03;
    localparam logic [5:0] CNTR_ADDR  = 6'h04;

endpackage

// File: rtl/timer_bus_initiator_if.sv
// -----------------------------------------------------------------------------
// timer_bus_initiator_if
// Timer register bus between the initiator and the timer's register slave.
//   bus_addr   : register address          (master -> slave)
//   bus_wr_en  : write qualifier           (master -> slave)
//   bus_mod_en : access strobe             (master -> slave)
//   bus_wdata  : write data                (master -> slave)
//   bus_rdata  : read data                 (slave  -> master)
// Modports: master (initiator side), slave (register block side).
// -----------------------------------------------------------------------------
interface timer_bus_initiator_if
    import timer_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [ADDR_W-1:0] bus_addr;
    logic              bus_wr_en;
    logic              bus_mod_en;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wr_en,
        output bus_mod_en,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wr_en,
        input  bus_mod_en,
        input  bus_wdata,
        output bus_rdata
    );

endinterface

// File: rtl/timer_bus_initiator.sv
// -----------------------------------------------------------------------------
// timer_bus_initiator
// Initiator end of the timer register bus. Accepts one read/write command at a
// time, runs a single bus access toward the register slave, waits RD_LAT cycles
// for read data and returns it on a valid/ready response channel.
//
// Ports:
//   clk, rst_b               : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake (cmd_write, cmd_addr, cmd_wdata)
//   resp_valid/resp_ready    : read response handshake (resp_rdata)
//   busy                     : FSM is not in IDLE
//   bus                      : timer_bus_initiator_if.master toward the slave
//
// Optional feature, macro TIMER_BUS_INITIATOR_POLL_EN:
//   adds cmd_poll, cmd_mask, cmd_max inputs and resp_timeout output. A polled
//   read repeats until (rdata & mask) == (wdata & mask) or cmd_max reads were
//   issued (0 counts as 1), with one idle bus cycle between reads.
//
// Parameters: ADDR_W, DATA_W, RD_LAT (0..3, 0 = combinational slave).
// -----------------------------------------------------------------------------
module timer_bus_initiator
    import timer_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
`ifdef TIMER_BUS_INITIATOR_POLL_EN
    input  logic                  cmd_poll,
    input  logic [DATA_W-1:0]     cmd_mask,
    input  logic [7:0]            cmd_max,
    output logic                  resp_timeout,
`endif
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  busy,
    timer_bus_initiator_if.master bus
);

    // Counter load for RD_WAIT; the last wait cycle is the one with count 0.
    localparam logic [1:0] LAT_LOAD = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    if (RD_LAT < 0 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("timer_bus_initiator: RD_LAT must be in 0..3");
    end

    state_t     state_r;
    logic       write_r;
    logic [1:0] lat_cnt_r;
    logic       gap_r;      // RD_WAIT is the idle cycle between two poll reads
    logic       capture_s;  // bus_rdata is valid for the outstanding read now
    logic       last_s;     // this capture completes the command

    // Decide whether the current cycle is the read-data capture cycle
    always_comb begin
        capture_s = 1'b0;
        if (state_r == ACCESS) begin
            capture_s = !write_r && (RD_LAT == 0);
        end else if (state_r == RD_WAIT) begin
            capture_s = !gap_r && (lat_cnt_r == 2'd0);
        end else begin
            capture_s = 1'b0;
        end
    end

`ifdef TIMER_BUS_INITIATOR_POLL_EN
    logic              poll_r;
    logic [DATA_W-1:0] mask_r;
    logic [7:0]        left_r;   // reads still allowed, including the current one
    logic              match_s;

    function automatic logic masked_eq(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b,
                                       input logic [DATA_W-1:0] m);
        return ((a ^ b) & m) == {DATA_W{1'b0}};
    endfunction

    // Poll termination: value matched or read budget used up
    always_comb begin
        match_s = masked_eq(bus.bus_rdata, bus.bus_wdata, mask_r);
        if (poll_r) begin
            last_s = match_s || (left_r == 8'd1);
        end else begin
            last_s = 1'b1;
        end
    end

    // Poll context: captured on accept, budget consumed on each capture
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            poll_r       <= 1'b0;
            mask_r       <= {DATA_W{1'b0}};
            left_r       <= 8'd0;
            resp_timeout <= 1'b0;
        end else if (state_r == IDLE && cmd_valid && cmd_ready) begin
            poll_r       <= cmd_poll && !cmd_write;
            mask_r       <= cmd_mask;
            left_r       <= (cmd_max == 8'd0) ? 8'd1 : cmd_max;
            resp_timeout <= 1'b0;
        end else if (capture_s) begin
            if (last_s) begin
                resp_timeout <= poll_r && !match_s;
            end else begin
                left_r       <= left_r - 8'd1;
                resp_timeout <= 1'b0;
            end
        end else begin
            left_r <= left_r;
        end
    end
`else
    assign last_s = 1'b1;
`endif

    // Initiator FSM with registered handshake and bus outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r        <= IDLE;
            cmd_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= {DATA_W{1'b0}};
            busy           <= 1'b0;
            write_r        <= 1'b0;
            lat_cnt_r      <= 2'd0;
            gap_r          <= 1'b0;
            bus.bus_addr   <= {ADDR_W{1'b0}};
            bus.bus_wr_en  <= 1'b0;
            bus.bus_mod_en <= 1'b0;
            bus.bus_wdata  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state_r        <= ACCESS;
                        cmd_ready      <= 1'b0;
                        busy           <= 1'b1;
                        write_r        <= cmd_write;
                        gap_r          <= 1'b0;
                        bus.bus_addr   <= cmd_addr;
                        bus.bus_wdata  <= cmd_wdata;
                        bus.bus_wr_en  <= cmd_write;
                        bus.bus_mod_en <= 1'b1;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ACCESS: begin
                    // Strobe lasts exactly this one cycle.
                    bus.bus_mod_en <= 1'b0;
                    bus.bus_wr_en  <= 1'b0;
                    if (write_r) begin
                        state_r   <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (capture_s) begin
                        resp_rdata <= bus.bus_rdata;
                        if (last_s) begin
                            state_r    <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state_r <= RD_WAIT;
                            gap_r   <= 1'b1;
                        end
                    end else begin
                        state_r   <= RD_WAIT;
                        lat_cnt_r <= LAT_LOAD;
                        gap_r     <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (gap_r) begin
                        // Idle cycle done: re-issue the poll read.
                        gap_r          <= 1'b0;
                        state_r        <= ACCESS;
                        bus.bus_mod_en <= 1'b1;
                    end else if (capture_s) begin
                        resp_rdata <= bus.bus_rdata;
                        if (last_s) begin
                            state_r    <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            gap_r <= 1'b1;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 2'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_r    <= IDLE;
                        resp_valid <= 1'b0;
                        cmd_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        resp_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    cmd_ready      <= 1'b0;
                    resp_valid     <= 1'b0;
                    busy           <= 1'b0;
                    bus.bus_wr_en  <= 1'b0;
                    bus.bus_mod_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_timer_bus_initiator
// Three initiators with RD_LAT = 0, 1 and 3, each with its own slave model.
// The slave drives the programmed read value only in the cycle the data is
// valid for its latency and changing junk at all other times.
// -----------------------------------------------------------------------------
module tb_timer_bus_initiator;
    import timer_bus_pkg::*;

    localparam int AW = 6;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid [3];
    logic          cmd_write [3];
    logic          cmd_ready [3];
    logic [AW-1:0] cmd_addr  [3];
    logic [DW-1:0] cmd_wdata [3];
    logic          resp_valid[3];
    logic          resp_ready[3];
    logic [DW-1:0] resp_rdata[3];
    logic          busy      [3];
    logic [AW-1:0] bus_addr  [3];
    logic          mod_en    [3];
    logic          wr_en     [3];
    logic [DW-1:0] bus_wdata [3];
`ifdef TIMER_BUS_INITIATOR_POLL_EN
    logic          cmd_poll    [3];
    logic [DW-1:0] cmd_mask    [3];
    logic [7:0]    cmd_max     [3];
    logic          resp_timeout[3];
`endif

    logic [DW-1:0] sl_seq [3][4];
    logic          sl_clr = 1'b0;
    logic [7:0]    rd_cnt [3];
    logic [7:0]    wr_cnt [3];
    logic [7:0]    viol_cnt [3];
    logic [AW-1:0] mon_addr [3];
    logic [DW-1:0] mon_wdata [3];
    logic [7:0]    cyc = 8'd0;
    always @(posedge clk) cyc <= cyc + 8'd1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT  = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        localparam int PIDX = (LAT == 0) ? 0 : LAT - 1;

        timer_bus_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

        timer_bus_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
            .clk        (clk),
            .rst_b      (rst_b),
            .cmd_valid  (cmd_valid[g]),
            .cmd_ready  (cmd_ready[g]),
            .cmd_write  (cmd_write[g]),
            .cmd_addr   (cmd_addr[g]),
            .cmd_wdata  (cmd_wdata[g]),
`ifdef TIMER_BUS_INITIATOR_POLL_EN
            .cmd_poll   (cmd_poll[g]),
            .cmd_mask   (cmd_mask[g]),
            .cmd_max    (cmd_max[g]),
            .resp_timeout(resp_timeout[g]),
`endif
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .busy       (busy[g]),
            .bus        (bif)
        );

        assign bus_addr[g]  = bif.bus_addr;
        assign mod_en[g]    = bif.bus_mod_en;
        assign wr_en[g]     = bif.bus_wr_en;
        assign bus_wdata[g] = bif.bus_wdata;

        // Slave model: read strobe delayed by LAT marks the valid data cycle.
        logic [3:0]    pipe_r = 4'd0;
        logic [7:0]    rc, wc;
        logic [7:0]    vc = 8'd0;
        logic          prev_mod = 1'b0;
        logic [AW-1:0] ma;
        logic [DW-1:0] mw;
        logic          rvalid;
        logic [1:0]    idx;

        always @(posedge clk) pipe_r <= {pipe_r[2:0], bif.bus_mod_en & ~bif.bus_wr_en};
        assign rvalid = (LAT == 0) ? (bif.bus_mod_en & ~bif.bus_wr_en) : pipe_r[PIDX];
        // Read k (0-based) of a command returns sl_seq[k].
        assign idx = (LAT == 0) ? rc[1:0] : 2'(rc - 8'd1);
        assign bif.bus_rdata = rvalid ? sl_seq[g][idx] : (8'hC3 ^ cyc);

        // Strobe monitor
        always @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                rc <= 8'd0; wc <= 8'd0; ma <= '0; mw <= '0;
            end else if (sl_clr) begin
                rc <= 8'd0; wc <= 8'd0;
            end else if (bif.bus_mod_en) begin
                if (bif.bus_wr_en) wc <= wc + 8'd1;
                else               rc <= rc + 8'd1;
                ma <= bif.bus_addr;
                mw <= bif.bus_wdata;
            end
        end

        // Protocol monitor: wr_en without mod_en, or a strobe longer than one cycle
        always @(posedge clk) begin
            prev_mod <= bif.bus_mod_en;
            if ((bif.bus_wr_en && !bif.bus_mod_en) || (bif.bus_mod_en && prev_mod))
                vc <= vc + 8'd1;
        end

        assign rd_cnt[g]    = rc;
        assign wr_cnt[g]    = wc;
        assign viol_cnt[g]  = vc;
        assign mon_addr[g]  = ma;
        assign mon_wdata[g] = mw;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [26:0] outs(input int g);
        return {cmd_ready[g], resp_valid[g], resp_rdata[g], bus_addr[g],
                mod_en[g], wr_en[g], bus_wdata[g], busy[g]};
    endfunction

    task automatic clear_mon();
        sl_clr = 1'b1;
        @(negedge clk);
        sl_clr = 1'b0;
    endtask

    // Offer a command once cmd_ready is seen; returns at the negedge after the
    // accepting edge (first ACCESS cycle, n = 1).
    task automatic issue(input int g, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k;
        k = 0;
        while (!cmd_ready[g] && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_before_issue", {31'd0, cmd_ready[g]}, 32'd1);
        cmd_valid[g] = 1'b1;
        cmd_write[g] = wr;
        cmd_addr[g]  = a;
        cmd_wdata[g] = d;
        @(negedge clk);
        cmd_valid[g] = 1'b0;
    endtask

    // n counts negedges after the accept edge; records first resp_valid / cmd_ready.
    task automatic observe(input int g, input int limit, output int resp_n, output int ready_n,
                           output logic [DW-1:0] rd);
        resp_n = 0; ready_n = 0; rd = '0;
        for (int n = 1; n <= limit; n++) begin
            if (resp_valid[g] && resp_n == 0) begin
                resp_n = n;
                rd = resp_rdata[g];
            end
            if (cmd_ready[g] && ready_n == 0) ready_n = n;
            if (resp_n != 0 || ready_n != 0) break;
            @(negedge clk);
        end
    endtask

    typedef struct {
        int            g;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] sdata;
        logic [DW-1:0] exp_rd;
        int            exp_n;   // write: n of cmd_ready; read: n of resp_valid (2 + RD_LAT)
    } vec_t;

    vec_t vecs [8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int rn, yn;
        logic [DW-1:0] rd;

        vecs[0] = '{1, 1'b1, CNTR_ADDR, 8'h5A, 8'h00, 8'h00, 2};
        vecs[1] = '{1, 1'b0, CNTR_ADDR, 8'h00, 8'hA5, 8'hA5, 3};
        vecs[2] = '{0, 1'b0, CMP_ADDR,  8'h00, 8'h11, 8'h11, 2};
        vecs[3] = '{2, 1'b0, STAT_ADDR, 8'h00, 8'h33, 8'h33, 5};
        vecs[4] = '{0, 1'b1, PRESC_ADDR, 8'h3C, 8'h00, 8'h00, 2};
        vecs[5] = '{2, 1'b1, CTRL_ADDR, 8'hFF, 8'h00, 8'h00, 2};
        vecs[6] = '{1, 1'b0, CTRL_ADDR, 8'h00, 8'h00, 8'h00, 3};
        vecs[7] = '{2, 1'b0, CNTR_ADDR, 8'h00, 8'hC0, 8'hC0, 5};

        for (int g = 0; g < 3; g++) begin
            cmd_valid[g] = 1'b0; cmd_write[g] = 1'b0; cmd_addr[g] = '0; cmd_wdata[g] = '0;
            resp_ready[g] = 1'b1;
`ifdef TIMER_BUS_INITIATOR_POLL_EN
            cmd_poll[g] = 1'b0; cmd_mask[g] = '0; cmd_max[g] = 8'd0;
`endif
            for (int j = 0; j < 4; j++) sl_seq[g][j] = 8'h00;
        end

        // Reset state, then cmd_ready one edge after release
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) check("reset_outputs", {5'd0, outs(g)}, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) check("ready_after_release", {31'd0, cmd_ready[g]}, 32'd1);

        // Table-driven single accesses across all three latencies
        for (int i = 0; i < 8; i++) begin
            clear_mon();
            for (int j = 0; j < 4; j++) sl_seq[vecs[i].g][j] = vecs[i].sdata;
            issue(vecs[i].g, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            observe(vecs[i].g, 12, rn, yn, rd);
            if (vecs[i].wr) begin
                check("wr_ready_latency", rn == 0 ? yn : 99, vecs[i].exp_n);
                check("wr_strobe_count", {24'd0, wr_cnt[vecs[i].g]}, 32'd1);
                check("wr_no_read_strobe", {24'd0, rd_cnt[vecs[i].g]}, 32'd0);
                check("wr_addr", {26'd0, mon_addr[vecs[i].g]}, {26'd0, vecs[i].addr});
                check("wr_data", {24'd0, mon_wdata[vecs[i].g]}, {24'd0, vecs[i].wdata});
            end else begin
                check("rd_resp_latency", rn, vecs[i].exp_n);
                check("rd_data", {24'd0, rd}, {24'd0, vecs[i].exp_rd});
                check("rd_strobe_count", {24'd0, rd_cnt[vecs[i].g]}, 32'd1);
                check("rd_no_write_strobe", {24'd0, wr_cnt[vecs[i].g]}, 32'd0);
                check("rd_addr", {26'd0, mon_addr[vecs[i].g]}, {26'd0, vecs[i].addr});
            end
            repeat (2) @(negedge clk);
        end

        // Response backpressure on RD_LAT=1: data held, new command refused
        clear_mon();
        resp_ready[1] = 1'b0;
        for (int j = 0; j < 4; j++) sl_seq[1][j] = 8'h77;
        issue(1, 1'b0, CNTR_ADDR, 8'h00);
        observe(1, 12, rn, yn, rd);
        check("bp_resp_latency", rn, 3);
        cmd_valid[1] = 1'b1; cmd_write[1] = 1'b1; cmd_addr[1] = PRESC_ADDR; cmd_wdata[1] = 8'h99;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold", {21'd0, resp_valid[1], resp_rdata[1], cmd_ready[1], busy[1]},
                  {21'd0, 1'b1, 8'h77, 1'b0, 1'b1});
        end
        check("bp_no_write_accepted", {24'd0, wr_cnt[1]}, 32'd0);
        cmd_valid[1] = 1'b0;
        resp_ready[1] = 1'b1;
        @(negedge clk);
        check("bp_release", {29'd0, resp_valid[1], cmd_ready[1], busy[1]}, 32'b010);

        // Reset while in RD_WAIT (RD_LAT=3)
        clear_mon();
        issue(2, 1'b0, STAT_ADDR, 8'h00);
        @(negedge clk);
        check("rdwait_bus_idle_addr_held", {24'd0, mod_en[2], wr_en[2], bus_addr[2]},
              {24'd0, 1'b0, 1'b0, STAT_ADDR});
        rst_b = 1'b0;
        #1;
        check("reset_in_rdwait", {5'd0, outs(2)}, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("rdwait_ready_after_release", {31'd0, cmd_ready[2]}, 32'd1);
        repeat (5) @(negedge clk);
        check("rdwait_no_stray_strobe", {16'd0, rd_cnt[2], wr_cnt[2]}, 32'd0);
        check("rdwait_no_stray_resp", {31'd0, resp_valid[2]}, 32'd0);

        // Reset while in RESP (RD_LAT=1)
        clear_mon();
        resp_ready[1] = 1'b0;
        for (int j = 0; j < 4; j++) sl_seq[1][j] = 8'h5C;
        issue(1, 1'b0, CNTR_ADDR, 8'h00);
        observe(1, 12, rn, yn, rd);
        check("resp_before_reset", {24'd0, rd}, 32'h5C);
        rst_b = 1'b0;
        #1;
        check("reset_in_resp", {5'd0, outs(1)}, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        resp_ready[1] = 1'b1;
        @(negedge clk);
        check("resp_ready_after_release", {31'd0, cmd_ready[1]}, 32'd1);
        repeat (3) @(negedge clk);
        check("resp_no_stray_strobe", {16'd0, rd_cnt[1], wr_cnt[1]}, 32'd0);

`ifdef TIMER_BUS_INITIATOR_POLL_EN
        // Poll: match on third read
        clear_mon();
        sl_seq[1][0] = 8'h00; sl_seq[1][1] = 8'h00; sl_seq[1][2] = 8'h03; sl_seq[1][3] = 8'h00;
        cmd_poll[1] = 1'b1; cmd_mask[1] = 8'h01; cmd_max[1] = 8'd4;
        issue(1, 1'b0, CNTR_ADDR, 8'h01);
        observe(1, 60, rn, yn, rd);
        check("poll_match_data", {24'd0, rd}, 32'h03);
        check("poll_match_reads", {24'd0, rd_cnt[1]}, 32'd3);
        check("poll_match_timeout", {31'd0, resp_timeout[1]}, 32'd0);
        repeat (2) @(negedge clk);

        // Poll: never matches, budget of four reads
        clear_mon();
        for (int j = 0; j < 4; j++) sl_seq[1][j] = 8'h00;
        issue(1, 1'b0, CNTR_ADDR, 8'h01);
        observe(1, 60, rn, yn, rd);
        check("poll_to_data", {24'd0, rd}, 32'h00);
        check("poll_to_reads", {24'd0, rd_cnt[1]}, 32'd4);
        check("poll_to_timeout", {31'd0, resp_timeout[1]}, 32'd1);
        repeat (2) @(negedge clk);

        // Poll: cmd_max = 0 behaves as a single read
        clear_mon();
        cmd_max[1] = 8'd0;
        issue(1, 1'b0, CNTR_ADDR, 8'h01);
        observe(1, 60, rn, yn, rd);
        check("poll_max0_reads", {24'd0, rd_cnt[1]}, 32'd1);
        check("poll_max0_timeout", {31'd0, resp_timeout[1]}, 32'd1);
        cmd_poll[1] = 1'b0;
        repeat (2) @(negedge clk);
`endif

        for (int g = 0; g < 3; g++) check("strobe_protocol", {24'd0, viol_cnt[g]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
